// File: rtl/mod3_pkg.sv
// Shared types and constants for the multiple-of-three detector.
package mod3_pkg;

  // State encoding equals the running remainder modulo 3.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  // The empty number 0 is divisible by 3.
  localparam state_t RESET_STATE = S0;

endpackage : mod3_pkg

// File: rtl/mod3_next_state.sv
// Next remainder after appending one bit as the new LSB: (2*rem + in) mod 3.
module mod3_next_state
  import mod3_pkg::*;
(
  input  state_t state_i,
  input  logic   in_i,
  output state_t next_o
);

  // Transition table; the unused encoding 2'd3 recovers to the reset state.
  always_comb begin
    next_o = RESET_STATE;
    case (state_i)
      S0:      next_o = in_i ? S1 : S0;
      S1:      next_o = in_i ? S0 : S2;
      S2:      next_o = in_i ? S2 : S1;
      default: next_o = RESET_STATE;
    endcase
  end

endmodule : mod3_next_state

// File: rtl/multiple_of_three_detector_fsm.sv
// Serial MSB-first multiple-of-three detector (Moore FSM).
// Optional status outputs (rem, bit_cnt) are built when MOD3_STATUS_EN is defined.
module multiple_of_three_detector_fsm
  import mod3_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             out
`ifdef MOD3_STATUS_EN
  ,
  output logic [1:0]       rem,
  output logic [CNT_W-1:0] bit_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  logic   out_q;

  mod3_next_state u_next_state (
    .state_i (state_q),
    .in_i    (in),
    .next_o  (state_d)
  );

  // State register and registered divisibility flag; reset wins over in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= (state_d == S0);
    end
  end

  assign out = out_q;

`ifdef MOD3_STATUS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bit_cnt_q;

  // Bits accepted since reset, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else if (bit_cnt_q != CNT_MAX) begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  assign rem     = 2'(state_q);
  assign bit_cnt = bit_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^32'(CNT_W);
`endif

endmodule : multiple_of_three_detector_fsm

// File: tb/tb_multiple_of_three_detector_fsm.sv
// Self-checking bench for multiple_of_three_detector_fsm (both MOD3_STATUS_EN builds).
module tb_multiple_of_three_detector_fsm;

`ifdef MOD3_STATUS_EN
  localparam int unsigned CNT_W = 4;
`else
  localparam int unsigned CNT_W = 8;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    bit rst;
    bit din;
    bit exp_out;
  } vec_t;

  typedef struct {
    bit exp_out;
    int exp_rem;
    int exp_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic dout;
`ifdef MOD3_STATUS_EN
  logic [1:0]       rem;
  logic [CNT_W-1:0] bit_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int m_rem    = 0;
  int m_cnt    = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  multiple_of_three_detector_fsm #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .out     (dout)
`ifdef MOD3_STATUS_EN
    ,
    .rem     (rem),
    .bit_cnt (bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model, push the expectation, then compare after the edge.
  task automatic apply(input bit r, input bit b, input bit exp_out, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = r;
    din   = b;
    if (r) begin
      m_rem = 0;
      m_cnt = 0;
    end else begin
      m_rem = (2 * m_rem + int'(b)) % 3;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    e.exp_out = exp_out;
    e.exp_rem = m_rem;
    e.exp_cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checks++;
    if (dout !== got.exp_out) begin
      failures++;
      $display("FAIL %s out: got %b expected %b", tag, dout, got.exp_out);
    end
`ifdef MOD3_STATUS_EN
    checks++;
    if (rem !== 2'(got.exp_rem)) begin
      failures++;
      $display("FAIL %s rem: got %0d expected %0d", tag, rem, got.exp_rem);
    end
    checks++;
    if (bit_cnt !== CNT_W'(got.exp_cnt)) begin
      failures++;
      $display("FAIL %s bit_cnt: got %0d expected %0d", tag, bit_cnt, got.exp_cnt);
    end
`endif
  endtask

  initial begin
    bit b;
    reset = 1'b1;
    din   = 1'b0;

    // Reset, then 1,0,0,1,0,1,0,1,0,1 -> 1,2,4,9,18,37,74,149,298,597.
    vecs.push_back('{1, 0, 1});
    vecs.push_back('{0, 1, 0});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{0, 1, 1});
    vecs.push_back('{0, 0, 1});
    vecs.push_back('{0, 1, 0});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{0, 1, 0});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{0, 1, 1});
    // Reset, then 1,1 (3) and 0,0 (6, 12).
    vecs.push_back('{1, 0, 1});
    vecs.push_back('{0, 1, 0});
    vecs.push_back('{0, 1, 1});
    vecs.push_back('{0, 0, 1});
    vecs.push_back('{0, 0, 1});
    // Reset, eight leading zeros.
    vecs.push_back('{1, 1, 1});
    for (int i = 0; i < 8; i++) vecs.push_back('{0, 0, 1});

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst, vecs[i].din, vecs[i].exp_out, $sformatf("vec%0d", i));

    // Mid-stream reset with in=1 discards remainder 2 and the bit itself.
    apply(1, 0, 1, "mid_rst_pre");
    apply(0, 1, 0, "mid_b1");
    apply(0, 0, 0, "mid_b0");
    apply(1, 1, 1, "mid_rst");
    apply(0, 1, 0, "mid_after");

    // Reset held several cycles with in=1 keeps out high.
    apply(1, 1, 1, "hold_rst0");
    apply(1, 1, 1, "hold_rst1");
    apply(1, 1, 1, "hold_rst2");

    // Long random stream: out follows reference remainder, counter saturates.
    apply(1, 0, 1, "rand_rst");
    for (int i = 0; i < 40; i++) begin
      int nxt;
      b = 1'($urandom_range(0, 1));
      nxt = (2 * m_rem + int'(b)) % 3;
      apply(0, b, (nxt == 0), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multiple_of_three_detector_fsm

// File: doc/multiple_of_three_detector_fsm.md
MULTIPLE_OF_THREE_DETECTOR_FSM -- requirements
Module: multiple_of_three_detector_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the optional bit counter (used only with MOD3_STATUS_EN).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in  input  1  next serial bit, MSB-first, appended as the new LSB of the running number.
REQ-005 SHALL have port out  output  1  1 when the number read so far is divisible by 3.
REQ-006 SHALL have, only with MOD3_STATUS_EN, port rem  output  2  current remainder (0..2) of the number read so far modulo 3.
REQ-007 SHALL have, only with MOD3_STATUS_EN, port bit_cnt  output  CNT_W  count of bits accepted since reset.

Function
REQ-008 SHALL implement a Moore FSM with three states: S0 (remainder 0), S1 (remainder 1), S2 (remainder 2).
REQ-009 SHALL compute next state as (2*remainder + in) mod 3 on each rising clk edge with reset low.
REQ-010 SHALL use these S0 transitions: in=0 -> S0, in=1 -> S1.
REQ-011 SHALL use these S1 transitions: in=0 -> S2, in=1 -> S0.
REQ-012 SHALL use these S2 transitions: in=0 -> S1, in=1 -> S2.
REQ-013 SHALL drive out = 1 exactly when the state is S0, decoded from the state register only, with no combinational path from in.
REQ-014 SHALL have one-cycle latency: a bit sampled at edge k is reflected on out after edge k.
REQ-015 SHALL accept one bit on every clock cycle, with no valid/ready handshake; the number length is unbounded and only the remainder is retained.
REQ-016 SHALL treat leading zeros as no-ops: in=0 while in S0 stays in S0.
REQ-017 SHALL, with MOD3_STATUS_EN, make bit_cnt increment by 1 per non-reset edge and saturate at 2^CNT_W-1 (no wrap), with rem equal to the state encoding.
REQ-018 SHALL recover any illegal state encoding to S0 on the next edge.

Reset
REQ-019 SHALL, when reset is high at a rising edge, force state to S0 (out=1, the empty number 0 being divisible) and, if enabled, bit_cnt=0 and rem=0.
REQ-020 SHALL give reset priority over in; the bit presented during a reset cycle is discarded.
REQ-021 SHALL, on reset asserted mid-stream, discard prior history; the first bit after reset release starts a new number.

Configuration
REQ-022 SHALL, with macro MOD3_STATUS_EN defined, compile in the rem and bit_cnt ports and the counter logic; without it, those ports and logic are absent and the module has only clk, reset, in and out.

Structure
REQ-023 SHALL place the 2-bit state typedef (S0=2'd0, S1=2'd1, S2=2'd2) and the reset-state constant in shared package mod3_pkg.
REQ-024 SHALL implement the next-state function as combinational sub-module mod3_next_state (inputs: state, in; output: next state), instantiated once.

Verification
REQ-025 SHALL cover reset for one edge -> out=1; with MOD3_STATUS_EN, rem=0 and bit_cnt=0.
REQ-026 SHALL cover the bit stream 1,0,0,1,0,1,0,1,0,1 (numbers 1,2,4,9,18,37,74,149,298,597) -> out per edge 0,0,0,1,1,0,0,0,0,1.
REQ-027 SHALL cover the bits 1,1 (number 3) -> out 0, then 1; then bits 0,0 (numbers 6, 12) -> out stays 1.
REQ-028 SHALL cover reset asserted after the bits 1,0 (remainder 2), with in=1 during reset -> out=1 after the reset edge; then bit 1 -> out=0 (number 1).
REQ-029 SHALL cover eight leading zeros after reset -> out stays 1 throughout.
REQ-030 SHALL cover, with MOD3_STATUS_EN and CNT_W=4, 20 bits applied -> bit_cnt saturates at 15, and rem matches the reference remainder on every edge.
